// File: rtl/uart_pkg.sv
// Shared definitions for the UART command decoder: sync byte, FSM states and byte-time helpers.
package uart_pkg;

    localparam logic [7:0] SYNC_BYTE     = 8'hA5;
    localparam int         BITS_PER_BYTE = 32'd10;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ADDR = 2'd1,
        ST_WAIT_DATA = 2'd2,
        ST_WAIT_CHK  = 2'd3
    } state_t;

    // Last counter value of the inter-byte gap, in clock cycles.
    function automatic int timeout_terminal(input int clk_speed, input int baud_rate,
                                            input int timeout_bytes);
        return timeout_bytes * BITS_PER_BYTE * (clk_speed / baud_rate) - 32'd1;
    endfunction

endpackage

// File: rtl/Counter.sv
// Generic up-counter with synchronous reset, load and count enable; load wins over enable.
module Counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // Count register.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Decodes SYNC/ADDR/DATA/CHK byte frames from a UART receiver into register writes,
// rejecting bad addresses, bad checksums and stalled frames.
module uart_cmd_decoder
    import uart_pkg::*;
#(
    parameter int CLK_SPEED     = 5_000_000,
    parameter int BAUD_RATE     = 9600,
    parameter int TIMEOUT_BYTES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       reg_wr_en,
    output logic [1:0] reg_addr,
    output logic [7:0] reg_wr_data,
    output logic       cmd_error,
    output logic       busy,
    output logic [7:0] err_count
);

    localparam int                   TMO_TERMINAL = timeout_terminal(CLK_SPEED, BAUD_RATE, TIMEOUT_BYTES);
    localparam int                   TMO_WIDTH    = $clog2(TMO_TERMINAL) + 1;
    localparam logic [TMO_WIDTH-1:0] TMO_LAST     = TMO_WIDTH'(TMO_TERMINAL);

    state_t               state_r;
    state_t               state_next_s;
    logic [1:0]           addr_lat_r;
    logic [7:0]           data_lat_r;
    logic [TMO_WIDTH-1:0] tmo_count_s;
    logic                 tmo_clear_s;
    logic                 tmo_en_s;
    logic                 tmo_hit_s;
    logic                 chk_ok_s;
    logic                 wr_fire_s;
    logic                 err_fire_s;

    assign tmo_clear_s = rx_valid | (state_r == ST_IDLE);
    assign tmo_en_s    = (state_r != ST_IDLE);
    // A byte arriving on the terminal cycle takes priority over the timeout.
    assign tmo_hit_s   = tmo_en_s & (tmo_count_s == TMO_LAST) & ~rx_valid;
    assign chk_ok_s    = (rx_data == ({6'b000000, addr_lat_r} ^ data_lat_r));
    assign busy        = (state_r != ST_IDLE);

    Counter #(.WIDTH(TMO_WIDTH)) u_timeout (
        .clock      (clock),
        .reset      (reset),
        .load       (tmo_clear_s),
        .load_value ({TMO_WIDTH{1'b0}}),
        .en         (tmo_en_s),
        .count      (tmo_count_s)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; SYNC is only recognised in IDLE.
    always_comb begin
        state_next_s = state_r;
        if (tmo_hit_s) begin
            state_next_s = ST_IDLE;
        end else if (rx_valid) begin
            case (state_r)
                ST_IDLE:      state_next_s = (rx_data == SYNC_BYTE) ? ST_WAIT_ADDR : ST_IDLE;
                ST_WAIT_ADDR: state_next_s = (rx_data[7:2] == 6'd0) ? ST_WAIT_DATA : ST_IDLE;
                ST_WAIT_DATA: state_next_s = ST_WAIT_CHK;
                ST_WAIT_CHK:  state_next_s = ST_IDLE;
                default:      state_next_s = ST_IDLE;
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // Write/error decisions, registered below so they appear one cycle after the event.
    always_comb begin
        wr_fire_s  = 1'b0;
        err_fire_s = 1'b0;
        if (tmo_hit_s) begin
            err_fire_s = 1'b1;
        end else if (rx_valid) begin
            case (state_r)
                ST_WAIT_ADDR: err_fire_s = (rx_data[7:2] != 6'd0);
                ST_WAIT_CHK: begin
                    wr_fire_s  = chk_ok_s;
                    err_fire_s = ~chk_ok_s;
                end
                default: begin
                    wr_fire_s  = 1'b0;
                    err_fire_s = 1'b0;
                end
            endcase
        end else begin
            wr_fire_s  = 1'b0;
            err_fire_s = 1'b0;
        end
    end

    // Address/data capture while the frame is in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_lat_r <= 2'd0;
            data_lat_r <= 8'd0;
        end else if (rx_valid && (state_r == ST_WAIT_ADDR)) begin
            addr_lat_r <= rx_data[1:0];
        end else if (rx_valid && (state_r == ST_WAIT_DATA)) begin
            data_lat_r <= rx_data;
        end else begin
            addr_lat_r <= addr_lat_r;
            data_lat_r <= data_lat_r;
        end
    end

    // Registered outputs; address/data hold until the next accepted frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            reg_wr_en   <= 1'b0;
            cmd_error   <= 1'b0;
            reg_addr    <= 2'd0;
            reg_wr_data <= 8'd0;
            err_count   <= 8'd0;
        end else begin
            reg_wr_en <= wr_fire_s;
            cmd_error <= err_fire_s;
            if (wr_fire_s) begin
                reg_addr    <= addr_lat_r;
                reg_wr_data <= data_lat_r;
            end else begin
                reg_addr    <= reg_addr;
                reg_wr_data <= reg_wr_data;
            end
            if (err_fire_s && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end else begin
                err_count <= err_count;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: scenario tasks plus a frame-level queue model.
module tb_uart_cmd_decoder;

    localparam int GAP = 4 * 10 * (5_000_000 / 9600);

    logic       clock;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       reg_wr_en;
    logic [1:0] reg_addr;
    logic [7:0] reg_wr_data;
    logic       cmd_error;
    logic       busy;
    logic [7:0] err_count;

    int tests = 0;
    int fails = 0;

    // Reference model state: bytes of the frame collected so far.
    logic [7:0] byte_q[$];
    int         cyc = 0;
    int         last_rx = 0;
    logic       exp_wr = 1'b0;
    logic       exp_err = 1'b0;
    logic       exp_busy = 1'b0;
    logic [1:0] exp_addr = 2'd0;
    logic [7:0] exp_data = 8'd0;
    int         exp_cnt = 0;

    int          trace_bad = 0;
    int          bad_cyc = 0;
    logic [20:0] bad_obs = '0;
    logic [20:0] bad_exp = '0;

    uart_cmd_decoder dut (
        .clock       (clock),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .reg_wr_en   (reg_wr_en),
        .reg_addr    (reg_addr),
        .reg_wr_data (reg_wr_data),
        .cmd_error   (cmd_error),
        .busy        (busy),
        .err_count   (err_count)
    );

    always #5 clock = ~clock;

    // One clock cycle: drive inputs, advance model, record any output divergence.
    task automatic step(input logic v, input logic [7:0] d, input logic r);
        logic       ew;
        logic       ee;
        logic [7:0] a;
        logic [20:0] obs;
        logic [20:0] expv;
        reset = r; rx_valid = v; rx_data = d;
        @(posedge clock); #1;
        cyc++;
        ew = 1'b0; ee = 1'b0;
        if (r) begin
            byte_q.delete();
            exp_addr = 2'd0; exp_data = 8'd0; exp_cnt = 0;
        end else if (v) begin
            last_rx = cyc;
            if (byte_q.size() == 0) begin
                if (d == 8'hA5) byte_q.push_back(d);
            end else begin
                byte_q.push_back(d);
                a = byte_q[1];
                if (byte_q.size() == 2 && a > 8'd3) begin
                    ee = 1'b1; byte_q.delete();
                end else if (byte_q.size() == 4) begin
                    if (byte_q[3] == (byte_q[1] ^ byte_q[2])) begin
                        ew = 1'b1; exp_addr = a[1:0]; exp_data = byte_q[2];
                    end else begin
                        ee = 1'b1;
                    end
                    byte_q.delete();
                end
            end
        end else if (byte_q.size() != 0 && (cyc - last_rx) == GAP) begin
            ee = 1'b1; byte_q.delete();
        end
        if (ee && exp_cnt < 255) exp_cnt++;
        exp_wr = ew; exp_err = ee; exp_busy = (byte_q.size() != 0);
        obs  = {reg_wr_en, cmd_error, busy, reg_addr, reg_wr_data, err_count};
        expv = {exp_wr, exp_err, exp_busy, exp_addr, exp_data, 8'(exp_cnt)};
        if (obs !== expv) begin
            if (trace_bad == 0) begin
                bad_cyc = cyc; bad_obs = obs; bad_exp = expv;
            end
            trace_bad++;
        end
        rx_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        for (int i = 0; i < gap; i++) step(1'b0, 8'h00, 1'b0);
        step(1'b1, b, 1'b0);
    endtask

    task automatic test_reset;
        trace_bad = 0;
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        tests++;
        if ({reg_wr_en, cmd_error, busy, reg_addr, reg_wr_data, err_count} !== 21'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %h want 0", {reg_wr_en, cmd_error, busy, reg_addr, reg_wr_data, err_count});
        end
    endtask

    task automatic test_good_frame;
        trace_bad = 0;
        send(8'hA5, 0); send(8'h02, 1); send(8'h3C, 2); send(8'h3E, 0);
        tests++;
        if (reg_wr_en !== 1'b1 || reg_addr !== 2'd2 || reg_wr_data !== 8'h3C || err_count !== 8'd0) begin
            fails++;
            $display("FAIL good_frame: wr=%b addr=%0d data=%h cnt=%0d want wr=1 addr=2 data=3c cnt=0",
                     reg_wr_en, reg_addr, reg_wr_data, err_count);
        end
        step(1'b0, 8'h00, 1'b0);
        tests++;
        if (reg_wr_en !== 1'b0 || reg_addr !== 2'd2 || busy !== 1'b0) begin
            fails++;
            $display("FAIL good_frame_pulse: wr=%b addr=%0d busy=%b want wr=0 addr=2 busy=0", reg_wr_en, reg_addr, busy);
        end
    endtask

    task automatic test_bad_chk;
        send(8'hA5, 0); send(8'h01, 0); send(8'h10, 0); send(8'h00, 0);
        tests++;
        if (cmd_error !== 1'b1 || reg_wr_en !== 1'b0 || err_count !== 8'd1 || busy !== 1'b0 || reg_wr_data !== 8'h3C) begin
            fails++;
            $display("FAIL bad_chk: err=%b wr=%b cnt=%0d busy=%b data=%h want err=1 wr=0 cnt=1 busy=0 data=3c",
                     cmd_error, reg_wr_en, err_count, busy, reg_wr_data);
        end
    endtask

    task automatic test_ignore_bad_addr;
        send(8'h00, 1); send(8'hFF, 0);
        tests++;
        if (busy !== 1'b0 || cmd_error !== 1'b0) begin
            fails++;
            $display("FAIL ignore_noise: busy=%b err=%b want 0 0", busy, cmd_error);
        end
        send(8'hA5, 0); send(8'h04, 0);
        tests++;
        if (cmd_error !== 1'b1 || busy !== 1'b0 || err_count !== 8'd2) begin
            fails++;
            $display("FAIL bad_addr: err=%b busy=%b cnt=%0d want err=1 busy=0 cnt=2", cmd_error, busy, err_count);
        end
        tests++;
        if (trace_bad !== 0) begin
            fails++;
            $display("FAIL trace_basic: %0d bad cycles, first cyc %0d got %h want %h", trace_bad, bad_cyc, bad_obs, bad_exp);
        end
    endtask

    task automatic test_timeout;
        trace_bad = 0;
        send(8'hA5, 0); send(8'h01, 0);
        for (int i = 0; i < GAP - 1; i++) step(1'b0, 8'h00, 1'b0);
        tests++;
        if (busy !== 1'b1 || cmd_error !== 1'b0) begin
            fails++;
            $display("FAIL timeout_early: busy=%b err=%b want busy=1 err=0", busy, cmd_error);
        end
        step(1'b0, 8'h00, 1'b0);
        tests++;
        if (cmd_error !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL timeout_fire: err=%b busy=%b want err=1 busy=0", cmd_error, busy);
        end
        send(8'hA5, 3); send(8'h01, 0);
        for (int i = 0; i < GAP - 1; i++) step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h20, 1'b0);
        tests++;
        if (cmd_error !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL timeout_byte_wins: err=%b busy=%b want err=0 busy=1", cmd_error, busy);
        end
        send(8'h21, 2);
        tests++;
        if (reg_wr_en !== 1'b1 || reg_addr !== 2'd1 || reg_wr_data !== 8'h20) begin
            fails++;
            $display("FAIL timeout_frame_done: wr=%b addr=%0d data=%h want 1 1 20", reg_wr_en, reg_addr, reg_wr_data);
        end
        tests++;
        if (trace_bad !== 0) begin
            fails++;
            $display("FAIL trace_timeout: %0d bad cycles, first cyc %0d got %h want %h", trace_bad, bad_cyc, bad_obs, bad_exp);
        end
    endtask

    task automatic test_reset_mid_frame;
        trace_bad = 0;
        send(8'hA5, 0); send(8'h03, 0);
        step(1'b0, 8'h00, 1'b1);
        tests++;
        if (busy !== 1'b0 || reg_wr_en !== 1'b0 || cmd_error !== 1'b0 || err_count !== 8'd0) begin
            fails++;
            $display("FAIL reset_mid: busy=%b wr=%b err=%b cnt=%0d want all 0", busy, reg_wr_en, cmd_error, err_count);
        end
        send(8'hA5, 1); send(8'h03, 0); send(8'h55, 0); send(8'h56, 0);
        tests++;
        if (reg_wr_en !== 1'b1 || reg_addr !== 2'd3 || reg_wr_data !== 8'h55 || cmd_error !== 1'b0) begin
            fails++;
            $display("FAIL reset_then_frame: wr=%b addr=%0d data=%h err=%b want 1 3 55 0",
                     reg_wr_en, reg_addr, reg_wr_data, cmd_error);
        end
    endtask

    task automatic test_random_frames;
        logic [7:0] a;
        logic [7:0] d;
        trace_bad = 0;
        send(8'hA5, 0); send(8'h01, 0); send(8'hA5, 0); send(8'hA4, 0);
        tests++;
        if (reg_wr_en !== 1'b1 || reg_addr !== 2'd1 || reg_wr_data !== 8'hA5) begin
            fails++;
            $display("FAIL sync_as_data: wr=%b addr=%0d data=%h want 1 1 a5", reg_wr_en, reg_addr, reg_wr_data);
        end
        for (int n = 0; n < 40; n++) begin
            a = 8'($urandom_range(0, 3));
            d = 8'($urandom);
            case ($urandom_range(0, 3))
                0: begin send(8'hA5, $urandom_range(0, 2)); send(a, $urandom_range(0, 2));
                         send(d, $urandom_range(0, 2)); send(a ^ d, $urandom_range(0, 2)); end
                1: begin send(8'hA5, 0); send(a, 0); send(d, 1); send(a ^ d ^ 8'(1 << $urandom_range(0, 7)), 0); end
                2: begin send(8'hA5, 1); send(8'($urandom_range(4, 255)), 0); end
                default: send(8'($urandom_range(0, 164)), $urandom_range(0, 3));
            endcase
        end
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
        tests++;
        if (trace_bad !== 0) begin
            fails++;
            $display("FAIL trace_random: %0d bad cycles, first cyc %0d got %h want %h", trace_bad, bad_cyc, bad_obs, bad_exp);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] d;
        trace_bad = 0;
        for (int n = 0; n < 8; n++) begin
            d = 8'($urandom);
            send(8'hA5, 0); send(8'(n % 4), 0); send(d, 0); send(8'(n % 4) ^ d, 0);
        end
        tests++;
        if (reg_wr_en !== 1'b1 || reg_addr !== 2'd3 || reg_wr_data !== d) begin
            fails++;
            $display("FAIL back_to_back_last: wr=%b addr=%0d data=%h want 1 3 %h", reg_wr_en, reg_addr, reg_wr_data, d);
        end
        tests++;
        if (trace_bad !== 0) begin
            fails++;
            $display("FAIL trace_b2b: %0d bad cycles, first cyc %0d got %h want %h", trace_bad, bad_cyc, bad_obs, bad_exp);
        end
    endtask

    task automatic test_saturate;
        trace_bad = 0;
        for (int n = 0; n < 260; n++) begin
            send(8'hA5, 0); send(8'h10, 0);
        end
        step(1'b0, 8'h00, 1'b0);
        tests++;
        if (err_count !== 8'd255 || cmd_error !== 1'b0) begin
            fails++;
            $display("FAIL err_saturate: cnt=%0d err=%b want cnt=255 err=0", err_count, cmd_error);
        end
        tests++;
        if (trace_bad !== 0) begin
            fails++;
            $display("FAIL trace_saturate: %0d bad cycles, first cyc %0d got %h want %h", trace_bad, bad_cyc, bad_obs, bad_exp);
        end
    endtask

    initial begin
        clock = 1'b0; reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        test_reset();
        test_good_frame();
        test_bad_chk();
        test_ignore_bad_addr();
        test_timeout();
        test_reset_mid_frame();
        test_random_frames();
        test_back_to_back();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
